// File: rtl/lea_dec_keysched.sv
// LEA-128 decryption key schedule: computes the 24 round keys one per cycle into a
// local buffer, then streams them out in reverse order (RK23 first) over valid/ready.
module lea_dec_keysched #(
    parameter int ROUNDS = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [191:0] rk,
    output logic [4:0]   rk_idx,
    output logic         rk_last
);

    localparam logic [4:0] LastRound = 5'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, GEN, OUT} state_t;

    state_t       state_q, state_d;
    logic [4:0]   roundCnt_q, roundCnt_d;
    logic [4:0]   outIdx_q, outIdx_d;
    logic [31:0]  t0_q, t1_q, t2_q, t3_q;
    logic [31:0]  t0_d, t1_d, t2_d, t3_d;
    logic         outVld_q, outVld_d;
    logic [127:0] rkData_q, rkData_d;
    logic [127:0] keyBuf [ROUNDS];
    logic         bufWe;
    logic [31:0]  delta;
    logic [31:0]  t0New, t1New, t2New, t3New;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {x, x} << amt;
        return dbl[63:32];
    endfunction

    always_comb begin
        case (roundCnt_q[1:0])
            2'd0:    delta = 32'hc3efe9db;
            2'd1:    delta = 32'h44626b02;
            2'd2:    delta = 32'h79e27c8a;
            default: delta = 32'h78df30ec;
        endcase
    end

    // Rotation offsets of the constant wrap mod 32 through the 5-bit adds.
    assign t0New = rol32(t0_q + rol32(delta, roundCnt_q),         5'd1);
    assign t1New = rol32(t1_q + rol32(delta, roundCnt_q + 5'd1),  5'd3);
    assign t2New = rol32(t2_q + rol32(delta, roundCnt_q + 5'd2),  5'd6);
    assign t3New = rol32(t3_q + rol32(delta, roundCnt_q + 5'd3),  5'd11);

    always_comb begin
        state_d    = state_q;
        roundCnt_d = roundCnt_q;
        outIdx_d   = outIdx_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        t3_d       = t3_q;
        outVld_d   = outVld_q;
        rkData_d   = rkData_q;
        bufWe      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    t0_d       = {key[119:96], key[127:120]};
                    t1_d       = {key[87:64],  key[95:88]};
                    t2_d       = {key[55:32],  key[63:56]};
                    t3_d       = {key[23:0],   key[31:24]};
                    roundCnt_d = '0;
                    state_d    = GEN;
                end
            end
            GEN: begin
                t0_d       = t0New;
                t1_d       = t1New;
                t2_d       = t2New;
                t3_d       = t3New;
                bufWe      = 1'b1;
                roundCnt_d = roundCnt_q + 5'd1;
                if (roundCnt_q == LastRound) begin
                    state_d  = OUT;
                    outIdx_d = LastRound;
                    outVld_d = 1'b0;
                end
            end
            OUT: begin
                // The buffer read is registered, so the first OUT cycle only primes rkData.
                if (!outVld_q) begin
                    rkData_d = keyBuf[outIdx_q];
                    outVld_d = 1'b1;
                end else if (rk_ready) begin
                    if (outIdx_q == 5'd0) begin
                        state_d  = IDLE;
                        outVld_d = 1'b0;
                    end else begin
                        outIdx_d = outIdx_q - 5'd1;
                        rkData_d = keyBuf[outIdx_q - 5'd1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (bufWe) begin
            keyBuf[roundCnt_q] <= {t0New, t1New, t2New, t3New};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            roundCnt_q <= '0;
            outIdx_q   <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            t2_q       <= '0;
            t3_q       <= '0;
            outVld_q   <= 1'b0;
            rkData_q   <= '0;
        end else begin
            state_q    <= state_d;
            roundCnt_q <= roundCnt_d;
            outIdx_q   <= outIdx_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            t3_q       <= t3_d;
            outVld_q   <= outVld_d;
            rkData_q   <= rkData_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign rk_valid = outVld_q;
    assign rk       = outVld_q ? {rkData_q[127:96], rkData_q[95:64], rkData_q[63:32],
                                  rkData_q[95:64], rkData_q[31:0], rkData_q[95:64]} : '0;
    assign rk_idx   = outVld_q ? outIdx_q : '0;
    assign rk_last  = outVld_q && (outIdx_q == 5'd0);

endmodule

// File: tb/tb_lea_dec_keysched.sv
// Directed bench for lea_dec_keysched: a reference LEA-128 key generator supplies
// expected round keys; latency, ordering, backpressure, collisions and resets are exercised.
module tb_lea_dec_keysched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [191:0] rk;
    logic [4:0]   rk_idx;
    logic         rk_last;

    int checks = 0;
    int errors = 0;

    localparam logic [191:0] ZeroKeyRk0 =
        192'h87dfd3b7_3efe9dbc_efe9dbc3_3efe9dbc_fa76f0fb_3efe9dbc;

    lea_dec_keysched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key      (key),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rolModel(input logic [31:0] x, input int n);
        int s;
        s = n % 32;
        if (s == 0) return x;
        return (x << s) | (x >> (32 - s));
    endfunction

    function automatic logic [31:0] deltaModel(input int m);
        case (m % 4)
            0:       return 32'hc3efe9db;
            1:       return 32'h44626b02;
            2:       return 32'h79e27c8a;
            default: return 32'h78df30ec;
        endcase
    endfunction

    // Encryption-side key generator: round keys RK0..RKidx computed forward from the key.
    function automatic logic [191:0] modelRk(input logic [127:0] k, input int idx);
        logic [31:0] t0, t1, t2, t3;
        t0 = {k[119:96], k[127:120]};
        t1 = {k[87:64],  k[95:88]};
        t2 = {k[55:32],  k[63:56]};
        t3 = {k[23:0],   k[31:24]};
        for (int i = 0; i <= idx; i++) begin
            t0 = rolModel(t0 + rolModel(deltaModel(i), i),     1);
            t1 = rolModel(t1 + rolModel(deltaModel(i), i + 1), 3);
            t2 = rolModel(t2 + rolModel(deltaModel(i), i + 2), 6);
            t3 = rolModel(t3 + rolModel(deltaModel(i), i + 3), 11);
        end
        return {t0, t1, t2, t1, t3, t1};
    endfunction

    task automatic checkOutput(input string tag, input logic [191:0] observed,
                               input logic [191:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] k);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts a run for k and checks all 24 keys; collide injects ignored starts with kOther.
    task automatic runAndCheck(input logic [127:0] k, input bit randReady,
                               input bit checkLatency, input bit collide,
                               input logic [127:0] kOther);
        int n;
        int got;
        int expIdx;
        bit xfer;
        applyStimulus(k);
        checkOutput("busy_after_start", 192'(busy), 192'(1'b1));
        n = 0;
        while (rk_valid !== 1'b1 && n < 100) begin
            start = collide && (n == 10);
            if (start) key = kOther;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (checkLatency) checkOutput("first_valid_latency", 192'(n), 192'(25));
        got    = 0;
        expIdx = 23;
        while (got < 24 && n < 2000) begin
            checkOutput("rk_valid", 192'(rk_valid), 192'(1'b1));
            checkOutput("rk_idx", 192'(rk_idx), 192'(expIdx));
            checkOutput("rk", rk, modelRk(k, expIdx));
            checkOutput("rk_last", 192'(rk_last), 192'(expIdx == 0));
            if (k == '0 && expIdx == 0) checkOutput("rk0_zero_key", rk, ZeroKeyRk0);
            xfer     = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            rk_ready = xfer;
            start    = collide && (got == 5 || expIdx == 0);
            if (start) key = kOther;
            @(negedge clk);
            n++;
            if (xfer) begin
                got++;
                expIdx--;
            end
        end
        start = 1'b0;
        checkOutput("transfer_count", 192'(got), 192'(24));
        checkOutput("valid_after_last", 192'(rk_valid), 192'(1'b0));
        checkOutput("busy_after_last", 192'(busy), 192'(1'b0));
    endtask

    task automatic checkOutputsZero(input string tag);
        checkOutput({tag, "_busy"},     192'(busy),     192'(1'b0));
        checkOutput({tag, "_rk_valid"}, 192'(rk_valid), 192'(1'b0));
        checkOutput({tag, "_rk"},       rk,             192'(0));
        checkOutput({tag, "_rk_idx"},   192'(rk_idx),   192'(0));
        checkOutput({tag, "_rk_last"},  192'(rk_last),  192'(1'b0));
    endtask

    initial begin
        int n;
        bit sawValid;
        rst_n    = 1'b0;
        start    = 1'b0;
        key      = '0;
        rk_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutputsZero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] zero key with latency check");
        runAndCheck('0, 1'b0, 1'b1, 1'b0, '0);

        $display("[TB] start collisions in GEN, OUT and final transfer");
        runAndCheck(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 1'b0, 1'b1, 1'b1,
                    128'hdeadbeef_cafef00d_01234567_89abcdef);
        runAndCheck(128'h3c4b5a69_78879685_a4b3c2d1_e0f00102, 1'b0, 1'b1, 1'b0, '0);

        $display("[TB] backpressure");
        for (int r = 0; r < 6; r++) begin
            runAndCheck({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b0, 1'b0, '0);
        end

        $display("[TB] reset during OUT");
        rk_ready = 1'b0;
        applyStimulus(128'h11111111_22222222_33333333_44444444);
        n = 0;
        while (rk_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("valid_before_reset", 192'(rk_valid), 192'(1'b1));
        #2 rst_n = 1'b0;
        #1 checkOutputsZero("async_reset_out");
        @(negedge clk);
        rst_n    = 1'b1;
        rk_ready = 1'b1;
        sawValid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            sawValid |= (rk_valid === 1'b1) || (busy === 1'b1);
        end
        checkOutput("no_spurious_after_reset", 192'(sawValid), 192'(1'b0));

        $display("[TB] reset during GEN then restart");
        applyStimulus(128'hffffffff_00000000_ffffffff_00000000);
        repeat (12) @(negedge clk);
        checkOutput("busy_mid_gen", 192'(busy), 192'(1'b1));
        #2 rst_n = 1'b0;
        #1 checkOutputsZero("async_reset_gen");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runAndCheck(128'h01234567_89abcdef_fedcba98_76543210, 1'b0, 1'b1, 1'b0, '0);

        $display("[TB] golden equivalence on random keys");
        for (int r = 0; r < 200; r++) begin
            runAndCheck({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0, 1'b0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lea_dec_keysched.md
Name: lea_dec_keysched

Overview:
- Iterative LEA-128 key schedule for the decryption datapath.
- Takes a 128-bit key and computes the 24 192-bit round keys sequentially, one round per cycle, into an internal buffer.
- Streams the keys in reverse order (RK23 first, RK0 last) over a valid/ready interface to the decryption round engine.
- It is the decrypt-side counterpart of the combinational encryption key generator and produces bit-identical RK values.

Parameters:
- ROUNDS, 24, number of round keys (fixed for LEA-128; other values unsupported).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  pulse; accepted only in IDLE
- key  input  128  cipher key; sampled on the accepted start edge
- busy  output  1  high whenever state != IDLE
- rk_valid  output  1  round key on rk is valid
- rk_ready  input  1  consumer accepts rk this cycle
- rk  output  192  round key {T0,T1,T2,T1,T3,T1}; zero when rk_valid low
- rk_idx  output  5  round index of rk (23 down to 0); zero when rk_valid low
- rk_last  output  1  rk_valid && rk_idx==0

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - busy, rk_valid, rk_last, rk, rk_idx all 0.
  - Round counter and T0..T3 cleared.
  - Key buffer contents are don't-care and need not be reset.
- Key word preparation:
  - W0={key[119:96],key[127:120]}, W1={key[87:64],key[95:88]}, W2={key[55:32],key[63:56]}, W3={key[23:0],key[31:24]}.
  - Each word is rotated left by 8.
- Constants: d0=c3efe9db, d1=44626b02, d2=79e27c8a, d3=78df30ec. d=d[i mod 4].
- Round i update (all additions mod 2^32, all rotation amounts mod 32):
  - T0=ROL1(T0+ROL(d,i))
  - T1=ROL3(T1+ROL(d,i+1))
  - T2=ROL6(T2+ROL(d,i+2))
  - T3=ROL11(T3+ROL(d,i+3))
  - RK_i={T0,T1,T2,T1,T3,T1} using the updated values.
- Buffer: 24 entries x 128 bits {T0,T1,T2,T3}. T1 is replicated only at the output.
- FSM, states IDLE, GEN, OUT:
  - IDLE: on start edge, load T0..T3=W0..W3, i=0, go to GEN, busy=1 from the next cycle.
  - GEN: each cycle compute round i, write buf[i], update T regs, i++. After the write of i=23, go to OUT with out_idx=23.
  - OUT: rk_valid=1, rk/rk_idx driven from buf[out_idx].
    - On rk_valid&&rk_ready, out_idx-- and the next key presents the following cycle. Back-to-back transfers are allowed, one per cycle.
    - On transfer with out_idx==0, go to IDLE; rk_valid is low the next cycle.
- Latency:
  - start accepted at edge E0, GEN occupies 24 cycles, rk_valid rises after edge E25.
  - Minimum start-to-last-transfer is 49 cycles with rk_ready held high.
- Stall: rk_ready low holds rk, rk_idx and rk_valid stable indefinitely. No timeout.
- start while busy: ignored entirely. key changes while busy have no effect.
- start in the same cycle as the final transfer: ignored, because state is still OUT. The next start is accepted the cycle after.
- Reset mid-GEN or mid-OUT: immediate abort to IDLE, outputs zeroed within the same reset assertion. The next start recomputes from scratch.
- rk_ready while rk_valid low: no effect.

Test Plan:
- Reset values: assert rst_n=0 mid-OUT (rk_valid=1) -> rk_valid, busy, rk, rk_idx, rk_last go 0 asynchronously. After release, state is IDLE and no spurious valid appears.
- Zero key: key=0, start, rk_ready=1 ->
  - rk_valid rises 25 cycles after the start edge, first rk_idx=23.
  - 24 consecutive transfers follow.
  - Final transfer has rk_idx=0, rk_last=1, rk=87dfd3b7_3efe9dbc_efe9dbc3_3efe9dbc_fa76f0fb_3efe9dbc.
- Golden equivalence: random keys (>=200) -> every rk_idx=k value equals RK_k from the encryption key generator for the same key. Order is strictly 23..0.
- Backpressure: random rk_ready with 50% duty -> rk and rk_idx stable while rk_valid&&!rk_ready. Exactly 24 transfers, none duplicated or skipped.
- Start collisions: pulse start during GEN cycle 10 with a different key, and again during OUT -> both ignored, output matches the first key. Start in the final-transfer cycle is ignored; start on the next cycle runs normally.
- Abort/restart: reset during GEN round 12, then start with key A -> full correct 24-key sequence for A, with no leftover data from the aborted run.
